// File: rtl/sdram_arb2.sv
// sdram_arb2: two-client round-robin arbiter in front of the SDRAM byte controller.
// It serialises client byte reads/writes onto one wr/rd/rdy/val port and routes
// each read result back to its owner. A read with no mem_val is abandoned after
// RD_TIMEOUT cycles.
//
// Handshakes: a client raises cN_req with cN_we/addr/wdata stable and holds it
// until it sees cN_gnt. cN_gnt is high for the single cycle that ends with the
// controller taking the command, i.e. the posedge where (mem_wr|mem_rd) &
// mem_rdy. A request is sampled only in IDLE, so dropping it earlier cancels it.
// Once latched, the command always completes. Read data comes back later as a
// one-cycle cN_rvalid pulse. mem_val is honoured only in WAIT_RD.
module sdram_arb2 #(
    parameter int ADDR_DEPTH = 24,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c0_req,
    input  logic                  c0_we,
    input  logic [ADDR_DEPTH-1:0] c0_addr,
    input  logic [7:0]            c0_wdata,
    output logic                  c0_gnt,
    output logic                  c0_rvalid,
    output logic [7:0]            c0_rdata,
    input  logic                  c1_req,
    input  logic                  c1_we,
    input  logic [ADDR_DEPTH-1:0] c1_addr,
    input  logic [7:0]            c1_wdata,
    output logic                  c1_gnt,
    output logic                  c1_rvalid,
    output logic [7:0]            c1_rdata,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [ADDR_DEPTH-1:0] mem_addr,
    output logic [7:0]            mem_data_wr,
    input  logic                  mem_rdy,
    input  logic                  mem_val,
    input  logic [7:0]            mem_data_rd,
    output logic                  rd_timeout,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    // The counter value seen on the edge that declares the timeout.
    localparam logic [7:0] TO_LAST = 8'(RD_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_owner;     // client that owns the command in flight
    logic       r_last;      // client granted most recently
    logic [7:0] r_cnt;       // WAIT_RD cycle counter, saturating
    logic       w_any_req;
    logic       w_pick;
    logic       w_take;
    logic       w_val_hit;
    logic       w_to_hit;

    assign w_any_req = c0_req | c1_req;
    // On contention the client not granted last time wins; a lone requester always wins.
    assign w_pick    = (c0_req & c1_req) ? ~r_last : c1_req;
    assign w_take    = (r_state == ST_ISSUE) & mem_rdy;
    assign w_val_hit = (r_state == ST_WAIT_RD) & mem_val;
    assign w_to_hit  = (r_state == ST_WAIT_RD) & ~mem_val & (r_cnt == TO_LAST);

    assign c0_gnt    = w_take & ~r_owner;
    assign c1_gnt    = w_take & r_owner;
    assign dbg_state = r_state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a write returns to IDLE on accept, a read waits for data or timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_rdy) begin
                    w_next = mem_wr ? ST_IDLE : ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (w_val_hit || w_to_hit) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Latch the winner's command in IDLE; hold it until the controller takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            mem_data_wr <= '0;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_owner     <= w_pick;
            mem_wr      <= w_pick ? c1_we : c0_we;
            mem_rd      <= w_pick ? ~c1_we : ~c0_we;
            mem_addr    <= w_pick ? c1_addr : c0_addr;
            mem_data_wr <= w_pick ? c1_wdata : c0_wdata;
        end else if (w_take) begin
            mem_wr <= 1'b0;
            mem_rd <= 1'b0;
        end
    end

    // Round-robin history: updated on every grant, reset so that c0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_take) begin
            r_last <= r_owner;
        end
    end

    // Read timeout counter: cleared on accept, counts while waiting, saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_take) begin
            r_cnt <= 8'd0;
        end else if ((r_state == ST_WAIT_RD) && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Route returned read data to the owner and raise the one-cycle response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_rvalid  <= 1'b0;
            c1_rvalid  <= 1'b0;
            c0_rdata   <= 8'd0;
            c1_rdata   <= 8'd0;
            rd_timeout <= 1'b0;
        end else begin
            c0_rvalid  <= 1'b0;
            c1_rvalid  <= 1'b0;
            rd_timeout <= w_to_hit;
            if (w_val_hit) begin
                if (r_owner) begin
                    c1_rvalid <= 1'b1;
                    c1_rdata  <= mem_data_rd;
                end else begin
                    c0_rvalid <= 1'b1;
                    c0_rdata  <= mem_data_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_arb2.sv
// tb_sdram_arb2: directed bench for sdram_arb2 with a controller stub and a
// scoreboard of expected grants, read returns and timeouts.
module tb_sdram_arb2;

    localparam int AW = 24;
    localparam int TO = 20;
    localparam int GW = 3 + AW + 8;

    logic          clk;
    logic          rst_n;
    logic          c0_req, c0_we, c0_gnt, c0_rvalid;
    logic [AW-1:0] c0_addr;
    logic [7:0]    c0_wdata, c0_rdata;
    logic          c1_req, c1_we, c1_gnt, c1_rvalid;
    logic [AW-1:0] c1_addr;
    logic [7:0]    c1_wdata, c1_rdata;
    logic          mem_wr, mem_rd, mem_rdy, mem_val, rd_timeout;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data_wr, mem_data_rd;
    logic [1:0]    dbg_state;

    sdram_arb2 #(.ADDR_DEPTH(AW), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data_wr(mem_data_wr),
        .mem_rdy(mem_rdy), .mem_val(mem_val), .mem_data_rd(mem_data_rd),
        .rd_timeout(rd_timeout), .dbg_state(dbg_state)
    );

    int chk_cnt = 0;
    int fail_cnt = 0;
    int rv0_cnt = 0;
    int rv1_cnt = 0;
    bit stub_drop_val = 0;
    bit stub_stray = 0;

    logic [GW-1:0] exp_gnt_q[$];
    logic [7:0]    exp_rd0_q[$];
    logic [7:0]    exp_rd1_q[$];
    logic [7:0]    exp_to_q[$];
    logic [7:0]    mem_model [logic [AW-1:0]];

    logic [AW-1:0] a0_tab [5] = '{24'h000010, 24'h000101, 24'h000102, 24'h000103, 24'h000104};
    logic [7:0]    d0_tab [5] = '{8'h11, 8'h31, 8'h32, 8'h33, 8'h34};
    logic [AW-1:0] a1_tab [5] = '{24'h000020, 24'h000201, 24'h000202, 24'h000203, 24'h000204};
    logic [7:0]    d1_tab [5] = '{8'h22, 8'h41, 8'h42, 8'h43, 8'h44};

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        fail_cnt++;
        $display("FAIL watchdog: got no end of test, required end within 400000 time units");
        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        chk_cnt++;
        fail_cnt++;
        $display("FAIL %s: got 0x%0h, required no event", name, act);
    endtask

    function automatic logic [GW-1:0] cmd(input logic c, input logic we,
                                         input logic [AW-1:0] a, input logic [7:0] d);
        return {c, we, ~we, a, d};
    endfunction

    task automatic check_all_zero(input string name);
        check(name, {c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
                     mem_wr, mem_rd, mem_addr, mem_data_wr, rd_timeout}, 64'd0);
    endtask

    // driver: raise req with a stable command, wait for gnt, drop req
    task automatic do_req(input int c, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        int n;
        bit got;
        n = 0;
        got = 0;
        if (c == 0) begin
            c0_we = we; c0_addr = a; c0_wdata = d; c0_req = 1'b1;
        end else begin
            c1_we = we; c1_addr = a; c1_wdata = d; c1_req = 1'b1;
        end
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = (c == 0) ? c0_gnt : c1_gnt;
        end
        if (c == 0) c0_req = 1'b0;
        else        c1_req = 1'b0;
        if (!got) fail_now($sformatf("gnt_wait_c%0d", c), 64'(n));
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_gnt_q.size() + exp_rd0_q.size() + exp_rd1_q.size() + exp_to_q.size()) != 0
               && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_gnt_q.size() + exp_rd0_q.size() + exp_rd1_q.size() + exp_to_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // monitor: pops and compares whenever the DUT presents a grant or read return
    initial begin
        logic [GW-1:0] act;
        forever begin
            @(negedge clk);
            if (c0_gnt || c1_gnt) begin
                check("gnt_onehot", 64'(c0_gnt & c1_gnt), 64'd0);
                act = {c1_gnt, mem_wr, mem_rd, mem_addr, mem_data_wr};
                if (exp_gnt_q.size() == 0) fail_now("gnt_unexpected", 64'(act));
                else check("gnt_cmd", 64'(act), 64'(exp_gnt_q.pop_front()));
            end
            if (c0_rvalid) begin
                rv0_cnt++;
                if (exp_rd0_q.size() == 0) fail_now("c0_rvalid_unexpected", 64'(c0_rdata));
                else check("c0_rdata", 64'(c0_rdata), 64'(exp_rd0_q.pop_front()));
            end
            if (c1_rvalid) begin
                rv1_cnt++;
                if (exp_rd1_q.size() == 0) fail_now("c1_rvalid_unexpected", 64'(c1_rdata));
                else check("c1_rdata", 64'(c1_rdata), 64'(exp_rd1_q.pop_front()));
            end
        end
    end

    // controller stub: one stall cycle per command, read data three cycles after accept
    initial begin
        int wait_n, rd_pend, cyc, acc_cyc;
        bit rd_out, prev_rd;
        logic [7:0] rd_data;
        mem_rdy = 1'b0; mem_val = 1'b0; mem_data_rd = 8'd0;
        wait_n = 0; rd_pend = 0; cyc = 0; acc_cyc = 0;
        rd_out = 0; prev_rd = 0; rd_data = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_val = 1'b0;
            if (!rst_n) begin
                mem_rdy = 1'b0; wait_n = 0; rd_pend = 0; rd_out = 0; prev_rd = 0;
            end else begin
                if (rd_timeout) begin
                    rd_out = 0;
                    if (exp_to_q.size() == 0) fail_now("timeout_unexpected", 64'(cyc - acc_cyc));
                    else check("timeout_latency", 64'(cyc - acc_cyc), 64'(exp_to_q.pop_front()));
                end
                if (rd_pend > 0) begin
                    rd_pend--;
                    if (rd_pend == 0 && !stub_drop_val) begin
                        mem_val = 1'b1;
                        mem_data_rd = rd_data;
                        rd_out = 0;
                    end
                end
                if (stub_stray) begin
                    mem_val = 1'b1;
                    mem_data_rd = 8'hEE;
                    stub_stray = 0;
                end
                if (mem_rd && !prev_rd) check("rd_while_outstanding", 64'(rd_out), 64'd0);
                prev_rd = mem_rd;
                if (mem_wr || mem_rd) begin
                    if (wait_n < 1) begin
                        mem_rdy = 1'b0;
                        wait_n++;
                    end else begin
                        mem_rdy = 1'b1;
                        wait_n = 0;
                        check("accept_while_outstanding", 64'(rd_out), 64'd0);
                        if (mem_wr) begin
                            mem_model[mem_addr] = mem_data_wr;
                        end else begin
                            rd_data = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 8'h00;
                            rd_pend = 3;
                            rd_out = 1;
                            acc_cyc = cyc + 1;
                        end
                    end
                end else begin
                    mem_rdy = 1'b0;
                    wait_n = 0;
                end
            end
        end
    end

    // directed test sequence
    initial begin
        int n;
        rst_n = 1'b0;
        c0_req = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
        c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        // contention: both request continuously, grants alternate c0, c1, ...
        for (int i = 0; i < 5; i++) begin
            exp_gnt_q.push_back(cmd(1'b0, 1'b1, a0_tab[i], d0_tab[i]));
            exp_gnt_q.push_back(cmd(1'b1, 1'b1, a1_tab[i], d1_tab[i]));
        end
        fork
            begin
                for (int i = 0; i < 5; i++) do_req(0, 1'b1, a0_tab[i], d0_tab[i]);
            end
            begin
                for (int i = 0; i < 5; i++) do_req(1, 1'b1, a1_tab[i], d1_tab[i]);
            end
        join
        wait_drain("contention_drain");

        // single write then read by c0
        exp_gnt_q.push_back(cmd(1'b0, 1'b1, 24'h123456, 8'hA5));
        exp_gnt_q.push_back(cmd(1'b0, 1'b0, 24'h123456, 8'h00));
        exp_rd0_q.push_back(8'hA5);
        do_req(0, 1'b1, 24'h123456, 8'hA5);
        do_req(0, 1'b0, 24'h123456, 8'h00);
        wait_drain("wr_rd_drain");
        check("wr_rd_rv0_count", 64'(rv0_cnt), 64'd1);
        check("wr_rd_rv1_count", 64'(rv1_cnt), 64'd0);
        check("wr_rd_c1_rdata", 64'(c1_rdata), 64'd0);
        check("wr_rd_c0_rdata_hold", 64'(c0_rdata), 64'hA5);

        // interleaved reads: c0 was granted last, so c1 goes first
        exp_gnt_q.push_back(cmd(1'b1, 1'b0, 24'h000020, 8'h00));
        exp_gnt_q.push_back(cmd(1'b0, 1'b0, 24'h000010, 8'h00));
        exp_rd0_q.push_back(8'h11);
        exp_rd1_q.push_back(8'h22);
        fork
            do_req(0, 1'b0, 24'h000010, 8'h00);
            do_req(1, 1'b0, 24'h000020, 8'h00);
        join
        wait_drain("interleave_drain");
        check("interleave_rv0_count", 64'(rv0_cnt), 64'd2);
        check("interleave_rv1_count", 64'(rv1_cnt), 64'd1);

        // byte lanes: adjacent addresses keep their own bytes
        exp_gnt_q.push_back(cmd(1'b1, 1'b1, 24'h000A00, 8'h5C));
        exp_gnt_q.push_back(cmd(1'b1, 1'b1, 24'h000A01, 8'hA3));
        exp_gnt_q.push_back(cmd(1'b1, 1'b0, 24'h000A00, 8'h00));
        exp_gnt_q.push_back(cmd(1'b1, 1'b0, 24'h000A01, 8'h00));
        exp_rd1_q.push_back(8'h5C);
        exp_rd1_q.push_back(8'hA3);
        do_req(1, 1'b1, 24'h000A00, 8'h5C);
        do_req(1, 1'b1, 24'h000A01, 8'hA3);
        do_req(1, 1'b0, 24'h000A00, 8'h00);
        do_req(1, 1'b0, 24'h000A01, 8'h00);
        wait_drain("byte_lane_drain");
        check("byte_lane_rv1_count", 64'(rv1_cnt), 64'd3);

        // timeout: read never answered, pending c1 write granted afterwards
        stub_drop_val = 1;
        exp_gnt_q.push_back(cmd(1'b0, 1'b0, 24'h123456, 8'h00));
        exp_gnt_q.push_back(cmd(1'b1, 1'b1, 24'h000300, 8'h77));
        exp_to_q.push_back(8'(TO));
        fork
            do_req(0, 1'b0, 24'h123456, 8'h00);
            begin
                repeat (5) @(negedge clk);
                do_req(1, 1'b1, 24'h000300, 8'h77);
            end
        join
        wait_drain("timeout_drain");
        stub_drop_val = 0;
        check("timeout_rv0_count", 64'(rv0_cnt), 64'd2);
        check("timeout_rv1_count", 64'(rv1_cnt), 64'd3);

        // stray mem_val while idle is ignored
        stub_stray = 1;
        repeat (4) @(negedge clk);
        check("stray_rv0_count", 64'(rv0_cnt), 64'd2);
        check("stray_rv1_count", 64'(rv1_cnt), 64'd3);

        // reset while a read is outstanding
        stub_drop_val = 1;
        exp_gnt_q.push_back(cmd(1'b0, 1'b0, 24'h000010, 8'h00));
        do_req(0, 1'b0, 24'h000010, 8'h00);
        n = 0;
        while (dbg_state != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_read");
        check("reset_mid_read_state", 64'(dbg_state), 64'd0);
        stub_drop_val = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        exp_gnt_q.push_back(cmd(1'b0, 1'b1, 24'h000400, 8'h99));
        exp_gnt_q.push_back(cmd(1'b1, 1'b1, 24'h000500, 8'h98));
        fork
            do_req(0, 1'b1, 24'h000400, 8'h99);
            do_req(1, 1'b1, 24'h000500, 8'h98);
        join
        wait_drain("post_reset_drain");
        check("post_reset_rv0_count", 64'(rv0_cnt), 64'd2);
        check("post_reset_rv1_count", 64'(rv1_cnt), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/sdram_arb2.md
# sdram_arb2

Two-client round-robin arbiter placed directly upstream of the W9825G6KH SDRAM byte controller. It accepts byte read/write requests from two independent masters and serialises them onto the controller's single wr/rd/rdy/val port. It routes each read result back to the client that issued it. It also guards against a read that never completes by using a timeout.

## Interface
Parameters:
- ADDR_DEPTH, 24, byte address width (matches controller addr_in)
- RD_TIMEOUT, 64, cycles to wait for mem_val after a read is accepted; legal range 4..255

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller
- rst_n  in  1  reset, asynchronous, active-low; the top level drives controller rst = ~rst_n
- c0_req, c1_req  in  1  client request; held high until cN_gnt
- c0_we, c1_we  in  1  1 = write, 0 = read; stable while req is high
- c0_addr, c1_addr  in  ADDR_DEPTH  byte address; stable while req is high
- c0_wdata, c1_wdata  in  8  write byte; stable while req is high
- c0_gnt, c1_gnt  out  1  combinational one-cycle accept pulse
- c0_rvalid, c1_rvalid  out  1  registered one-cycle read-data pulse
- c0_rdata, c1_rdata  out  8  read byte; holds its value until the next rvalid for that client
- mem_wr, mem_rd  out  1  controller write/read strobe, registered
- mem_addr  out  ADDR_DEPTH  controller address, registered
- mem_data_wr  out  8  controller write data, registered
- mem_rdy  in  1  controller ready; a command is taken at a posedge where (mem_wr|mem_rd) & mem_rdy
- mem_val  in  1  controller read-data-valid pulse
- mem_data_rd  in  8  controller read data, valid with mem_val
- rd_timeout  out  1  registered one-cycle pulse when a read times out

## Operation
- State machine states:
  - IDLE: if any cN_req is high, select the owner and register its we/addr/wdata onto the mem_* outputs. Assert mem_wr or mem_rd and go to ISSUE.
  - ISSUE: hold the mem_* outputs. On the edge where mem_rdy=1:
    - clear mem_wr and mem_rd;
    - cN_gnt for the owner is high during that cycle (cN_gnt = state==ISSUE & mem_rdy & owner==N);
    - write: go to IDLE; read: clear the timeout counter and go to WAIT_RD.
  - WAIT_RD:
    - On mem_val=1: register mem_data_rd into the owner's cN_rdata, pulse the owner's cN_rvalid on the next cycle, and go to IDLE.
    - Otherwise the counter increments. When it reaches RD_TIMEOUT-1 without mem_val: pulse rd_timeout, leave cN_rvalid low and cN_rdata unchanged, and go to IDLE.
- Arbitration:
  - If both clients request in IDLE, the client not granted last time wins.
  - The last_grant register updates on each gnt and resets to 1, so c0 wins first.
  - If a single client requests, it wins regardless of last_grant.
- At most one read is outstanding. Writes are posted: no response is returned.
- A request is sampled only in IDLE:
  - Dropping cN_req before the arbiter leaves IDLE cancels that request.
  - Once the arbiter is in ISSUE, the latched command completes and the owner's gnt still pulses, even if its req has dropped.
- mem_val is ignored outside WAIT_RD, so a late response after a timeout is discarded.
- The timeout counter is 8 bits wide and saturates. It is cleared on entry to WAIT_RD.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, last_grant=1, counter=0. All outputs are 0: mem_wr, mem_rd, mem_addr, mem_data_wr, cN_gnt, cN_rvalid, cN_rdata, rd_timeout.
- Reset asserted mid-transaction abandons it immediately. The controller is reset by the same signal.
- Request path:
  - cN_req rises before edge E0; mem_wr or mem_rd is high after E0.
  - If mem_rdy=1 in the following cycle, the command is accepted at E1 and gnt is high in the cycle before E1.
  - The minimum spacing between issued commands is 2 cycles (ISSUE, then IDLE).
- Read return: mem_val is sampled high at edge Ev; cN_rvalid and cN_rdata update after Ev, and rvalid lasts exactly one cycle.
- Timeout: rd_timeout goes high exactly RD_TIMEOUT cycles after the read-accept edge.
- mem_rdy low in ISSUE stalls indefinitely; no timeout applies to ISSUE.

## Test plan
- Single write then read: c0 writes 0xA5 to 0x123456, then reads 0x123456.
  - Required: one gnt per request; mem_wr asserted with mem_data_wr=0xA5.
  - Required: c0_rvalid pulses once with c0_rdata=0xA5; c1 outputs stay 0.
- Contention: c0 and c1 raise req in the same cycle after reset, c0 writing 0x11 to 0x10 and c1 writing 0x22 to 0x20.
  - Required: c0 is granted first, then c1.
  - Repeat 4 times with both requesting continuously. Required: grants strictly alternate c0, c1, c0, c1.
- Interleaved reads: c0 reads 0x10 and c1 reads 0x20 after the contention writes.
  - Required: c0_rvalid carries 0x11 only to c0, and c1_rvalid carries 0x22 only to c1.
  - Required: the second mem_rd is not asserted until the first read's mem_val has been seen.
- Byte lanes: c1 writes 0x5C to 0x000A00, then 0xA3 to 0x000A01, then reads both addresses.
  - Required: the reads return 0x5C and 0xA3 respectively.
- Timeout: a controller stub never asserts mem_val for a read.
  - Required: rd_timeout pulses RD_TIMEOUT cycles after accept, no rvalid is asserted, and the arbiter returns to IDLE and grants the next pending write.
  - Then inject a stray mem_val while in IDLE. Required: no rvalid.
- Reset mid-read: deassert rst_n while in WAIT_RD.
  - Required: all outputs are 0 immediately.
  - After release, the first simultaneous request from both clients grants c0.
